// File: rtl/leb128_if.sv
// leb128_if: control, byte-stream and result bundle between the ROM/cpu side (master) and the decoder (slave)
interface leb128_if;
  logic        start;
  logic        is_signed;
  logic        width64;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic [63:0] result;
  logic [3:0]  length;
  logic        result_valid;
  logic        error;
  modport master (output start, is_signed, width64, byte_in, byte_valid,
                  input  byte_ready, busy, result, length, result_valid, error);
  modport slave  (input  start, is_signed, width64, byte_in, byte_valid,
                  output byte_ready, busy, result, length, result_valid, error);
endinterface

// File: rtl/leb128_decoder.sv
// leb128_decoder: byte-serial signed/unsigned LEB128 decoder (32/64-bit limits); ports: clk, reset, bus (leb128_if.slave)
module leb128_decoder (
  input logic     clk,
  input logic     reset,
  leb128_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;
  state_t      r_state;
  logic        r_busy, r_ready, r_valid, r_err, r_signed, r_w64;
  logic [63:0] r_acc, r_result;
  logic [6:0]  r_shift;
  logic [3:0]  r_count, r_length;
  logic [7:0]  w_b;
  logic [63:0] w_acc, w_sx, w_ext;
  logic [6:0]  w_shift;
  logic [3:0]  w_count;
  logic        w_last, w_canon, w_ok;
  always_comb begin
    w_b     = bus.byte_in;
    w_count = r_count + 4'd1;
    w_shift = r_shift + 7'd7;
    w_acc   = r_acc | ({57'd0, w_b[6:0]} << r_shift);
    w_sx    = (r_signed && w_shift < 7'd64 && w_b[6]) ? (w_acc | ({64{1'b1}} << w_shift)) : w_acc;
    w_ext   = r_w64 ? w_sx : r_signed ? {{32{w_sx[31]}}, w_sx[31:0]} : {32'd0, w_sx[31:0]};
    w_last  = w_count == (r_w64 ? 4'd10 : 4'd5);
    // unused high bits of the limit byte must be zero, or copies of the sign bit
    w_canon = r_w64 ? (r_signed ? (w_b[6:0] == 7'h00 || w_b[6:0] == 7'h7F) : w_b[6:1] == 6'd0)
                    : (r_signed ? (w_b[6:3] == 4'h0 || w_b[6:3] == 4'hF) : w_b[6:4] == 3'd0);
    w_ok    = !w_last || w_canon;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 64'd0;
      r_length <= 4'd0;
      r_acc    <= 64'd0;
      r_shift  <= 7'd0;
      r_count  <= 4'd0;
      r_signed <= 1'b0;
      r_w64    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state  <= ACCUM;
          r_busy   <= 1'b1;
          r_ready  <= 1'b1;
          r_signed <= bus.is_signed;
          r_w64    <= bus.width64;
          r_acc    <= 64'd0;
          r_shift  <= 7'd0;
          r_count  <= 4'd0;
        end
        ACCUM: if (bus.byte_valid && r_ready) begin
          r_acc   <= w_acc;
          r_shift <= w_shift;
          r_count <= w_count;
          if (!w_b[7] && w_ok) begin
            r_state  <= DONE;
            r_ready  <= 1'b0;
            r_valid  <= 1'b1;
            r_result <= w_ext;
            r_length <= w_count;
          end else if (!w_b[7] || w_last) begin
            r_state  <= ERR;
            r_ready  <= 1'b0;
            r_err    <= 1'b1;
            r_result <= 64'd0;
            r_length <= w_count;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.byte_ready   = r_ready;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.length       = r_length;
  assign bus.result_valid = r_valid;
  assign bus.error        = r_err;
endmodule
